// File: rtl/eth_pkg.sv
// eth_pkg: shared FSM state type, framing constants and bit-reversal helper for the Ethernet TX framer.
package eth_pkg;

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} eth_tx_state_e;

    localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] ETH_SFD_BYTE      = 8'hD5;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

endpackage

// File: rtl/eth_tx_framer_crc32.sv
// crc32: MSB-first CRC register, all-ones init, sync init via rst_i plus async active-low reset.
module crc32 #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY = 32'h04C11DB7
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  rst_i,
    input  logic                  crc_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_WIDTH-1:0]  crc_data_o
);

    logic [CRC_WIDTH-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = DATA_WIDTH - 1; i >= 0; i--)
            crc_d = {crc_d[CRC_WIDTH-2:0], 1'b0} ^ ((crc_d[CRC_WIDTH-1] ^ data_i[i]) ? POLY : '0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)       crc_q <= '1;
        else if (rst_i)    crc_q <= '1;
        else if (crc_en_i) crc_q <= crc_d;
    end

    assign crc_data_o = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: AXI-Stream byte payload to GMII byte stream (preamble, SFD, payload, FCS, IFG).
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes before the FCS.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int MIN_FRAME    = 60
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] s_tdata_i,
    input  logic       s_tvalid_i,
    input  logic       s_tlast_i,
    output logic       s_tready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_en_o,
    output logic       tx_er_o
);

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 2);
    localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
`ifdef ETH_TX_PAD_EN
    localparam logic [10:0] MIN_L    = 11'(MIN_FRAME);
`endif

    eth_tx_state_e state_q;
    logic [15:0]   cnt_q;
    logic [10:0]   byte_cnt_q, byte_nxt;
    logic          flush_q;
    logic [7:0]    tx_data_q;
    logic          tx_en_q, tx_er_q;
    logic [31:0]   crc_data;
    logic [7:0]    fcs_byte;
    logic          beat;

    assign s_tready_o = (state_q == DATA) || (state_q == IFG && flush_q);
    assign beat       = s_tvalid_i && s_tready_o;
    assign byte_nxt   = (byte_cnt_q == 11'd2047) ? byte_cnt_q : byte_cnt_q + 11'd1;
    // FCS byte k comes from crc bits [31-8k -: 8], sent LSB first and inverted
    assign fcs_byte   = ~bitrev8(8'(crc_data >> {~cnt_q[1:0], 3'b000}));

    crc32 #(.DATA_WIDTH(8), .CRC_WIDTH(32)) u_crc32 (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .rst_i      (~rstn_i | (state_q == IDLE)),
        .crc_en_i   ((beat && state_q == DATA) || state_q == PAD),
        .data_i     ((state_q == DATA) ? bitrev8(s_tdata_i) : 8'h00),
        .crc_data_o (crc_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            flush_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
        end else begin
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            cnt_q     <= cnt_q + 16'd1;
            case (state_q)
                IDLE: begin
                    cnt_q      <= '0;
                    byte_cnt_q <= '0;
                    if (s_tvalid_i) begin
                        state_q   <= (PREAMBLE_LEN == 1) ? SFD : PRE;
                        tx_data_q <= ETH_PREAMBLE_BYTE;
                        tx_en_q   <= 1'b1;
                    end
                end
                PRE: begin
                    tx_data_q <= ETH_PREAMBLE_BYTE;
                    tx_en_q   <= 1'b1;
                    if (cnt_q == PRE_LAST) state_q <= SFD;
                end
                SFD: begin
                    tx_data_q <= ETH_SFD_BYTE;
                    tx_en_q   <= 1'b1;
                    state_q   <= DATA;
                end
                DATA: begin
                    tx_en_q <= 1'b1;
                    if (s_tvalid_i) begin
                        tx_data_q  <= s_tdata_i;
                        byte_cnt_q <= byte_nxt;
                        if (s_tlast_i) begin
                            cnt_q <= '0;
`ifdef ETH_TX_PAD_EN
                            state_q <= (byte_nxt < MIN_L) ? PAD : FCS;
`else
                            state_q <= FCS;
`endif
                        end
                    end else begin
                        // underrun: poison the frame and drop the rest of it upstream
                        tx_er_q <= 1'b1;
                        cnt_q   <= '0;
                        flush_q <= 1'b1;
                        state_q <= IFG;
                    end
                end
`ifdef ETH_TX_PAD_EN
                PAD: begin
                    tx_en_q    <= 1'b1;
                    byte_cnt_q <= byte_nxt;
                    if (byte_nxt == MIN_L) begin
                        cnt_q   <= '0;
                        state_q <= FCS;
                    end
                end
`endif
                FCS: begin
                    tx_data_q <= fcs_byte;
                    tx_en_q   <= 1'b1;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_q   <= '0;
                        state_q <= IFG;
                    end
                end
                IFG: begin
                    cnt_q <= (cnt_q == IFG_LAST) ? cnt_q : cnt_q + 16'd1;
                    if (beat && s_tlast_i) flush_q <= 1'b0;
                    if (cnt_q == IFG_LAST && (!flush_q || (s_tvalid_i && s_tlast_i))) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data_o = tx_data_q;
    assign tx_en_o   = tx_en_q;
    assign tx_er_o   = tx_er_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed + random frames checked against a byte-level frame model with software CRC-32.
module tb_eth_tx_framer;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [7:0] s_tdata_i = 8'h00;
    logic       s_tvalid_i = 1'b0;
    logic       s_tlast_i = 1'b0;
    logic       s_tready_o;
    logic [7:0] tx_data_o;
    logic       tx_en_o;
    logic       tx_er_o;

    int total = 0;
    int bad   = 0;

    logic [9:0] mon[$];
    int         rd = 0;
    bit         mon_on = 1'b0;

    eth_tx_framer dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .s_tdata_i  (s_tdata_i),
        .s_tvalid_i (s_tvalid_i),
        .s_tlast_i  (s_tlast_i),
        .s_tready_o (s_tready_o),
        .tx_data_o  (tx_data_o),
        .tx_en_o    (tx_en_o),
        .tx_er_o    (tx_er_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (mon_on) mon.push_back({tx_en_o, tx_er_o, tx_data_o});

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sw_crc(input logic [7:0] d[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (d[i]) begin
            c ^= {24'h0, d[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // expected visible frame, one {tx_en, tx_er, data} entry per tx_en cycle
    task automatic expect_frame(input logic [7:0] p_in[$], input int under, output logic [9:0] f[$]);
        logic [7:0]  p[$];
        logic [31:0] c;
        p = p_in;
        f.delete();
        repeat (7) f.push_back({2'b10, 8'h55});
        f.push_back({2'b10, 8'hD5});
        if (under >= 0) begin
            for (int i = 0; i < under; i++) f.push_back({2'b10, p[i]});
            f.push_back({2'b11, 8'h00});
            return;
        end
`ifdef ETH_TX_PAD_EN
        while (p.size() < 60) p.push_back(8'h00);
`endif
        foreach (p[i]) f.push_back({2'b10, p[i]});
        c = sw_crc(p);
        for (int k = 0; k < 4; k++) f.push_back({2'b10, c[8*k +: 8]});
    endtask

    task automatic get_frame(output logic [9:0] f[$], output int gap);
        int guard = 0;
        bit done = 1'b0;
        f.delete();
        gap = 0;
        while (!done && guard < 4000) begin
            if (rd >= mon.size()) begin
                guard++;
                @(negedge clk_i);
                #1;
            end else if (!mon[rd][9]) begin
                if (f.size() > 0) done = 1'b1;
                else begin
                    gap++;
                    rd++;
                end
            end else begin
                f.push_back(mon[rd]);
                rd++;
            end
        end
        chk("frame_seen", 32'(done), 32'd1);
    endtask

    task automatic cmp_frame(input string tag, input logic [7:0] p[$], input int under,
                             output int gap, output logic [9:0] g[$]);
        logic [9:0] e[$];
        expect_frame(p, under, e);
        get_frame(g, gap);
        chk({tag, "_len"}, 32'(g.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < g.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(g[i]), 32'(e[i]));
    endtask

    task automatic send(input logic [7:0] p[$], input int stall_at);
        int i = 0;
        int guard = 0;
        bit stalled = 1'b0;
        while (i < p.size() && guard < 5000) begin
            @(negedge clk_i);
            guard++;
            if (i == stall_at && !stalled && s_tready_o) begin
                s_tvalid_i = 1'b0;
                stalled = 1'b1;
            end else begin
                s_tvalid_i = 1'b1;
                s_tdata_i  = p[i];
                s_tlast_i  = (i == p.size() - 1);
                if (s_tready_o) i++;
            end
        end
        chk("send_done", 32'(i), 32'(p.size()));
    endtask

    task automatic idle();
        @(negedge clk_i);
        s_tvalid_i = 1'b0;
        s_tlast_i  = 1'b0;
    endtask

    initial begin
        logic [7:0] p1[$], pa[$], pb[$], pc[$], pd[$], pe[$];
        logic [7:0] rp[6][$];
        logic [9:0] g[$];
        int gap, n, guard;

        rstn_i = 1'b1;
        #1 rstn_i = 1'b0;
        #2;
        chk("rst_data", 32'(tx_data_o), 32'h00);
        chk("rst_en", 32'(tx_en_o), 32'd0);
        chk("rst_er", 32'(tx_er_o), 32'd0);
        chk("rst_tready", 32'(s_tready_o), 32'd0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        mon_on = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            chk("idle_en", 32'(tx_en_o), 32'd0);
            chk("idle_tready", 32'(s_tready_o), 32'd0);
            chk("idle_crc", dut.u_crc32.crc_data_o, 32'hFFFF_FFFF);
        end

        p1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send(p1, -1);
        idle();
        cmp_frame("t1", p1, -1, gap, g);
`ifndef ETH_TX_PAD_EN
        chk("t1_en_cycles", 32'(g.size()), 32'd21);
        if (g.size() >= 4)
            chk("t1_fcs", {g[g.size()-4][7:0], g[g.size()-3][7:0], g[g.size()-2][7:0], g[g.size()-1][7:0]},
                32'h2639_F4CB);
`else
        pa = '{8'hAB};
        send(pa, -1);
        idle();
        cmp_frame("t2", pa, -1, gap, g);
        chk("t2_en_cycles", 32'(g.size()), 32'd72);
`endif

        pa = '{8'h10, 8'h11, 8'h12, 8'h13};
        pb = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        send(pa, -1);
        send(pb, -1);
        idle();
        cmp_frame("t3a", pa, -1, gap, g);
        cmp_frame("t3b", pb, -1, gap, g);
        chk("t3_ifg", 32'(gap), 32'd12);

        pc = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        pd = '{8'h5A, 8'h6B, 8'h7C};
        send(pc, 5);
        send(pd, -1);
        idle();
        cmp_frame("t4_err", pc, 5, gap, g);
        cmp_frame("t4_next", pd, -1, gap, g);

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(70, 2);
            for (int i = 0; i < n; i++) rp[f].push_back(8'($urandom));
        end
        for (int f = 0; f < 6; f++) send(rp[f], -1);
        idle();
        for (int f = 0; f < 6; f++) begin
            cmp_frame($sformatf("rnd%0d", f), rp[f], -1, gap, g);
            if (f > 0) chk($sformatf("rnd%0d_ifg", f), 32'(gap), 32'd12);
        end

        @(negedge clk_i);
        s_tvalid_i = 1'b1;
        s_tlast_i  = 1'b0;
        guard = 0;
        while (!s_tready_o && guard < 50) begin
            @(negedge clk_i);
            s_tdata_i = 8'($urandom);
            guard++;
        end
        chk("t5_reached_data", 32'(s_tready_o), 32'd1);
        repeat (3) begin
            @(negedge clk_i);
            s_tdata_i = 8'($urandom);
        end
        #1;
        chk("t5_en_before", 32'(tx_en_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("t5_en_async", 32'(tx_en_o), 32'd0);
        chk("t5_tready_async", 32'(s_tready_o), 32'd0);
        s_tvalid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        mon.delete();
        rd = 0;
        pe = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
        send(pe, -1);
        idle();
        cmp_frame("t5_after", pe, -1, gap, g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
